ac_motor_gate_guard: RTL and testbench
======================================

# ac_motor_gate_guard

Gate-output protection stage between the three switch-delay (dead-time) instances and the inverter gate drivers. It takes the six dead-timed gate requests, runs a bootstrap precharge before first switching, and blocks outputs on shoot-through or a filtered overcurrent. Faults latch until software clears them. Every gate output is registered and forced low outside the RUN state.

## Interface
- PRECHARGE, 8: cycles all three low-side gates are held on in ARM (bootstrap charge), 1..65535
- FAULT_FILTER, 3: consecutive high samples of fault_in needed to trip, 1..15
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  level; 1 = request switching, 0 = stop
- fault_clear  input  1  single-cycle pulse; clears a latched fault
- fault_in  input  1  overcurrent comparator, active high, synchronous to clk
- s1_high, s1_low, s2_high, s2_low, s3_high, s3_low  input  1 each  dead-timed gate requests per leg
- g1_high, g1_low, g2_high, g2_low, g3_high, g3_low  output  1 each  registered gate drives
- running  output  1  1 while in RUN
- fault  output  1  latched fault flag
- fault_code  output  2  0 none, 1 shoot-through, 2 overcurrent, 3 both in same cycle

## Operation
- States: IDLE, ARM, RUN, FAULT. Reset (reset_n low, any time, asynchronous): state IDLE, all g* 0, running 0, fault 0, fault_code 0, counters 0.
- IDLE: all g* 0. enable=1 -> ARM, precharge counter loaded 0.
- ARM: g1_low=g2_low=g3_low=1, all g*_high 0. Counter increments each cycle; after PRECHARGE cycles in ARM -> RUN. enable=0 -> IDLE (gates 0 next cycle).
- RUN: each g* = corresponding s* sampled on the previous edge; running=1. enable=0 -> IDLE.
- Shoot-through: in RUN, any leg with sX_high=1 and sX_low=1 on a sampling edge -> FAULT; the offending pair never reaches the outputs (all g* 0 on that edge).
- Overcurrent filter: 4-bit counter of consecutive fault_in=1 samples, active in ARM and RUN, cleared when fault_in=0 or in IDLE/FAULT, saturates at 15. On the edge where the count reaches FAULT_FILTER -> FAULT, all g* 0.
- Same-edge shoot-through and overcurrent trip: fault_code=3.
- FAULT: all g* 0, fault=1, fault_code held, running 0. Exit only when fault_clear=1 and enable=0 and fault_in=0 on the same edge -> IDLE, fault=0, fault_code=0. fault_clear ignored in all other states or conditions.
- fault_in in IDLE is ignored.

## Timing
- All outputs change only on clk rising edge (except asynchronous reset).
- enable rise at edge N (sampled): state ARM at N, low gates high from N. RUN entered at N+PRECHARGE; first passthrough value (s* sampled at N+PRECHARGE) appears at N+PRECHARGE.
- RUN passthrough latency: 1 cycle from s* to g*.
- enable drop sampled at edge N in RUN/ARM: all g* 0 at N.
- Shoot-through sampled at N: g* 0, fault=1 at N.
- fault_in high at edges N..N+FAULT_FILTER-1: fault=1, g* 0 at N+FAULT_FILTER-1.
- fault_clear accepted at N: fault=0 at N; re-arm needs enable high afterwards.
- No output glitch between states: all g* are flops.

## Test plan
- Power-up: reset_n low then high, enable=0 -> all g*, running, fault, fault_code 0.
- Arm/precharge: PRECHARGE=8, enable=1 -> g*_low=1 for exactly 8 cycles, then running=1 and g1_high follows s1_high with 1-cycle latency for a toggling pattern.
- Shoot-through: in RUN force s2_high=s2_low=1 for one cycle -> all g* 0 same edge, fault=1, fault_code=1; fault_clear with enable=1 -> still FAULT; enable=0 and fault_clear -> IDLE, fault_code 0.
- Overcurrent filter: FAULT_FILTER=3; fault_in pulses of 2 cycles separated by 1 low cycle -> no trip; 3-cycle pulse -> fault=1, fault_code=2 on third sample.
- Simultaneous: shoot-through on the same edge as 3rd fault_in sample -> fault_code=3.
- Reset mid-RUN: assert reset_n low asynchronously between edges -> all g* 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/ac_motor_gate_guard.sv
// Gate-output protection between the dead-time stages and the inverter gate drivers.
// Runs a bootstrap precharge, passes gate requests through in RUN, and latches shoot-through/overcurrent faults.
module ac_motor_gate_guard #(
  parameter int unsigned PRECHARGE    = 8,
  parameter int unsigned FAULT_FILTER = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       fault_clear,
  input  logic       fault_in,
  input  logic       s1_high,
  input  logic       s1_low,
  input  logic       s2_high,
  input  logic       s2_low,
  input  logic       s3_high,
  input  logic       s3_low,
  output logic       g1_high,
  output logic       g1_low,
  output logic       g2_high,
  output logic       g2_low,
  output logic       g3_high,
  output logic       g3_low,
  output logic       running,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, FAULT} state_t;

  localparam logic [15:0] PRE_LAST   = 16'(PRECHARGE - 1);
  localparam logic [3:0]  FILT_LEVEL = 4'(FAULT_FILTER);
  localparam logic [5:0]  LOW_GATES  = 6'b010101;

  state_t      r_state;
  logic [15:0] r_preCnt;
  logic [3:0]  r_ocCnt;
  logic [5:0]  r_gates;
  logic        r_running;
  logic        r_fault;
  logic [1:0]  r_faultCode;

  state_t      w_nextState;
  logic [5:0]  w_nextGates;
  logic [1:0]  w_nextCode;
  logic [5:0]  w_sIn;
  logic        w_shoot;
  logic        w_precharged;
  logic        w_ocActive;
  logic [3:0]  w_ocInc;
  logic [3:0]  w_ocNext;
  logic        w_ocTrip;
  logic        w_shootTrip;

  assign w_sIn        = {s1_high, s1_low, s2_high, s2_low, s3_high, s3_low};
  assign w_shoot      = (s1_high & s1_low) | (s2_high & s2_low) | (s3_high & s3_low);
  assign w_precharged = (r_preCnt == PRE_LAST);
  assign w_ocActive   = (r_state == ARM) || (r_state == RUN);
  assign w_ocInc      = (r_ocCnt == 4'hF) ? r_ocCnt : r_ocCnt + 4'd1;
  assign w_ocNext     = (w_ocActive && fault_in) ? w_ocInc : 4'd0;
  assign w_ocTrip     = w_ocActive && fault_in && (w_ocInc >= FILT_LEVEL);
  // Shoot-through is checked on every edge whose requests would otherwise reach the gates,
  // including the ARM->RUN edge.
  assign w_shootTrip  = w_shoot &&
                        ((r_state == RUN) || ((r_state == ARM) && w_precharged && enable));

  always_comb begin
    w_nextState = r_state;
    w_nextGates = 6'b000000;
    w_nextCode  = r_faultCode;
    case (r_state)
      IDLE:    if (enable) w_nextState = ARM;
      ARM: begin
        if (w_ocTrip || w_shootTrip) w_nextState = FAULT;
        else if (!enable)            w_nextState = IDLE;
        else if (w_precharged)       w_nextState = RUN;
      end
      RUN: begin
        if (w_ocTrip || w_shootTrip) w_nextState = FAULT;
        else if (!enable)            w_nextState = IDLE;
      end
      FAULT:   if (fault_clear && !enable && !fault_in) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    if (w_ocTrip || w_shootTrip)  w_nextCode = {w_ocTrip, w_shootTrip};
    else if (w_nextState == IDLE) w_nextCode = 2'd0;

    if (w_nextState == ARM)      w_nextGates = LOW_GATES;
    else if (w_nextState == RUN) w_nextGates = w_sIn;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_preCnt    <= 16'd0;
      r_ocCnt     <= 4'd0;
      r_gates     <= 6'b000000;
      r_running   <= 1'b0;
      r_fault     <= 1'b0;
      r_faultCode <= 2'd0;
    end else begin
      r_state     <= w_nextState;
      r_preCnt    <= ((r_state == ARM) && (w_nextState == ARM)) ? r_preCnt + 16'd1 : 16'd0;
      r_ocCnt     <= w_ocNext;
      r_gates     <= w_nextGates;
      r_running   <= (w_nextState == RUN);
      r_fault     <= (w_nextState == FAULT);
      r_faultCode <= w_nextCode;
    end
  end

  assign {g1_high, g1_low, g2_high, g2_low, g3_high, g3_low} = r_gates;
  assign running    = r_running;
  assign fault      = r_fault;
  assign fault_code = r_faultCode;

endmodule

// File: tb/tb_ac_motor_gate_guard.sv
// Directed self-checking bench for ac_motor_gate_guard (PRECHARGE=8, FAULT_FILTER=3).
module tb_ac_motor_gate_guard;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       fault_clear;
  logic       fault_in;
  logic [5:0] sReq;
  logic       g1_high, g1_low, g2_high, g2_low, g3_high, g3_low;
  logic       running;
  logic       fault;
  logic [1:0] fault_code;
  logic [5:0] gates;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] LOW_GATES = 6'b010101;
  localparam logic [5:0] PAT_A     = 6'b100110;
  localparam logic [5:0] PAT_B     = 6'b011001;
  localparam logic [5:0] SHOOT2    = 6'b001100;

  ac_motor_gate_guard #(.PRECHARGE(8), .FAULT_FILTER(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fault_clear(fault_clear),
    .fault_in(fault_in),
    .s1_high(sReq[5]), .s1_low(sReq[4]), .s2_high(sReq[3]),
    .s2_low(sReq[2]), .s3_high(sReq[1]), .s3_low(sReq[0]),
    .g1_high(g1_high), .g1_low(g1_low), .g2_high(g2_high),
    .g2_low(g2_low), .g3_high(g3_high), .g3_low(g3_low),
    .running(running), .fault(fault), .fault_code(fault_code)
  );

  assign gates = {g1_high, g1_low, g2_high, g2_low, g3_high, g3_low};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input logic fin, input logic [5:0] s);
    enable      = en;
    fault_clear = clr;
    fault_in    = fin;
    sReq        = s;
  endtask

  // Advance one rising edge and settle 1 time unit past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic armToRun(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, PAT_A);
    repeat (9) tick();
    checkOutput(tag, {31'd0, running}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b000000);
    #12;
    checkOutput("reset_gates", {26'd0, gates}, 32'd0);
    checkOutput("reset_flags", {29'd0, running, fault, fault_code[0]}, 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_gates", {26'd0, gates}, 32'd0);
    checkOutput("idle_code", {30'd0, fault_code}, 32'd0);

    // Precharge: exactly 8 edges with only the low-side gates on.
    applyStimulus(1'b1, 1'b0, 1'b0, PAT_A);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("arm_gates_%0d", i), {26'd0, gates}, {26'd0, LOW_GATES});
      checkOutput($sformatf("arm_run_%0d", i), {31'd0, running}, 32'd0);
    end
    tick();
    checkOutput("run_entry", {31'd0, running}, 32'd1);
    checkOutput("run_first", {26'd0, gates}, {26'd0, PAT_A});
    for (int k = 0; k < 4; k++) begin
      sReq = (k % 2 == 0) ? PAT_B : PAT_A;
      checkOutput($sformatf("latency_hold_%0d", k), {26'd0, gates}, {26'd0, (k % 2 == 0) ? PAT_A : PAT_B});
      tick();
      checkOutput($sformatf("pass_%0d", k), {26'd0, gates}, {26'd0, sReq});
    end
    enable = 1'b0;
    tick();
    checkOutput("stop_gates", {26'd0, gates}, 32'd0);
    checkOutput("stop_run", {31'd0, running}, 32'd0);

    // Shoot-through on leg 2, then clear attempts.
    armToRun("st_arm");
    sReq = SHOOT2;
    tick();
    checkOutput("st_gates", {26'd0, gates}, 32'd0);
    checkOutput("st_fault", {31'd0, fault}, 32'd1);
    checkOutput("st_code", {30'd0, fault_code}, 32'd1);
    checkOutput("st_run", {31'd0, running}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'b000000);
    tick();
    checkOutput("clr_en_fault", {31'd0, fault}, 32'd1);
    checkOutput("clr_en_code", {30'd0, fault_code}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b000000);
    tick();
    checkOutput("noclr_fault", {31'd0, fault}, 32'd1);
    fault_clear = 1'b1;
    tick();
    checkOutput("clr_fault", {31'd0, fault}, 32'd0);
    checkOutput("clr_code", {30'd0, fault_code}, 32'd0);
    fault_clear = 1'b0;

    // Overcurrent filter: two 2-sample pulses must not trip, a 3-sample pulse must.
    armToRun("oc_arm");
    for (int p = 0; p < 2; p++) begin
      fault_in = 1'b1;
      tick();
      tick();
      checkOutput($sformatf("oc_short_%0d", p), {31'd0, fault}, 32'd0);
      fault_in = 1'b0;
      tick();
      checkOutput($sformatf("oc_gap_%0d", p), {31'd0, running}, 32'd1);
    end
    fault_in = 1'b1;
    tick();
    tick();
    checkOutput("oc_second", {31'd0, fault}, 32'd0);
    tick();
    checkOutput("oc_trip", {31'd0, fault}, 32'd1);
    checkOutput("oc_code", {30'd0, fault_code}, 32'd2);
    checkOutput("oc_gates", {26'd0, gates}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'b000000);
    tick();
    checkOutput("oc_clr_fin_high", {31'd0, fault}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'b000000);
    tick();
    checkOutput("oc_clr", {31'd0, fault}, 32'd0);
    fault_clear = 1'b0;

    // Shoot-through on the same edge as the third overcurrent sample.
    armToRun("both_arm");
    fault_in = 1'b1;
    tick();
    tick();
    checkOutput("both_pre", {31'd0, fault}, 32'd0);
    sReq = SHOOT2;
    tick();
    checkOutput("both_code", {30'd0, fault_code}, 32'd3);
    checkOutput("both_gates", {26'd0, gates}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'b000000);
    tick();
    checkOutput("both_clr", {30'd0, fault_code}, 32'd0);
    fault_clear = 1'b0;

    // Asynchronous reset between edges while running.
    armToRun("rst_arm");
    checkOutput("rst_pre_gates", {26'd0, gates}, {26'd0, PAT_A});
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_gates", {26'd0, gates}, 32'd0);
    checkOutput("rst_async_run", {31'd0, running}, 32'd0);
    enable = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    checkOutput("rst_idle_gates", {26'd0, gates}, 32'd0);
    checkOutput("rst_idle_run", {31'd0, running}, 32'd0);
    enable = 1'b1;
    tick();
    checkOutput("rst_rearm", {26'd0, gates}, {26'd0, LOW_GATES});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
